// File: rtl/gpo_ctrl.sv
// gpo_ctrl: general-purpose output controller.
// Command words arrive on a ready/valid stream. Each word carries an op in
// [DW+2:DW] and data or a mask in [DW-1:0]. The op acts on a DW-bit pin
// register: write, set, clear, toggle, timed pulse or read-back.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   inp_tdata/tvalid/tready command stream
//   out_tdata/tvalid/tready read-back stream (backpressured)
//   gpo                    registered output pins
//   busy                   pulse running or read-back pending

// Next value of one pin bit.
module gpo_ctrl_lane (
  input  logic       g,        // current pin value
  input  logic       d,        // command data bit
  input  logic       m,        // saved pulse mask bit
  input  logic [2:0] op,
  input  logic       apply,    // command accepted this cycle
  input  logic       restore,  // pulse expiring this cycle
  output logic       q
);
  always_comb begin
    q = g;
    if (restore) q = g ^ m;
    else if (apply) begin
      case (op)
        3'b000:  q = d;
        3'b001:  q = g | d;
        3'b010:  q = g & ~d;
        3'b011,
        3'b100:  q = g ^ d;          // a pulse starts as a toggle
        default: q = g;              // read-back and reserved ops
      endcase
    end
  end
endmodule

module gpo_ctrl #(
  parameter int            DW           = 8,
  parameter logic [DW-1:0] INIT_STATE   = '0,
  parameter int            PULSE_CYCLES = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [DW+2:0] inp_tdata,
  input  logic          inp_tvalid,
  output logic          inp_tready,
  output logic [DW-1:0] out_tdata,
  output logic          out_tvalid,
  input  logic          out_tready,
  output logic [DW-1:0] gpo,
  output logic          busy
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PULSE, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] mask, mask_nxt;
  logic [DW-1:0] gpo_nxt, otd_nxt;
  logic          otv_nxt;
  logic          apply, restore;

  logic [2:0]    op;
  logic [DW-1:0] data;
  assign op   = inp_tdata[DW+2:DW];
  assign data = inp_tdata[DW-1:0];

  assign inp_tready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask;
    otv_nxt   = out_tvalid;
    otd_nxt   = out_tdata;
    apply     = 1'b0;
    restore   = 1'b0;
    case (state)
      IDLE: begin
        if (inp_tvalid) begin
          apply = 1'b1;
          case (op)
            3'b100: begin
              mask_nxt  = data;
              // Counter counts down to zero; the restore edge is the one
              // that sees zero, so toggled bits live exactly PULSE_CYCLES.
              cnt_nxt   = CW'(PULSE_CYCLES - 1);
              state_nxt = PULSE;
            end
            3'b101: begin
              otd_nxt   = gpo;
              otv_nxt   = 1'b1;
              state_nxt = RESP;
            end
            default: ;
          endcase
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          restore   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      RESP: begin
        if (out_tready) begin
          otv_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < DW; i++) begin : g_lane
    gpo_ctrl_lane u_lane (
      .g       (gpo[i]),
      .d       (data[i]),
      .m       (mask[i]),
      .op      (op),
      .apply   (apply),
      .restore (restore),
      .q       (gpo_nxt[i])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cnt        <= '0;
      mask       <= '0;
      gpo        <= INIT_STATE;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mask       <= mask_nxt;
      gpo        <= gpo_nxt;
      out_tvalid <= otv_nxt;
      out_tdata  <= otd_nxt;
    end
  end
endmodule

// File: tb/tb_gpo_ctrl.sv
// Directed bench for gpo_ctrl (DW=8, INIT_STATE=0, PULSE_CYCLES=4).
module tb_gpo_ctrl;
  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW+2:0] inp_tdata;
  logic          inp_tvalid;
  logic          inp_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic [DW-1:0] gpo;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  gpo_ctrl #(.DW(DW), .INIT_STATE(8'h00), .PULSE_CYCLES(4)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .inp_tdata  (inp_tdata),
    .inp_tvalid (inp_tvalid),
    .inp_tready (inp_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .gpo        (gpo),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    inp_tdata  = {op, d};
    inp_tvalid = 1'b1;
  endtask

  task automatic idle_in;
    inp_tvalid = 1'b0;
    inp_tdata  = '0;
  endtask

  initial begin
    aresetn = 1'b0; out_tready = 1'b0; idle_in();
    // 1. reset and first write
    tick(); tick();
    chk("rst_gpo", 32'(gpo), 32'h00);
    chk("rst_tready", 32'(inp_tready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_otv", 32'(out_tvalid), 32'h0);
    chk("rst_otd", 32'(out_tdata), 32'h00);
    aresetn = 1'b1;
    send(3'b000, 8'hA5);
    chk("wr_tready", 32'(inp_tready), 32'h1);
    tick();
    chk("wr_gpo", 32'(gpo), 32'hA5);
    chk("wr_tready2", 32'(inp_tready), 32'h1);

    // 2. back-to-back set/clear/toggle from zero
    send(3'b000, 8'h00); tick();
    chk("b2b_zero", 32'(gpo), 32'h00);
    send(3'b001, 8'h0F); tick();
    chk("b2b_set", 32'(gpo), 32'h0F);
    chk("b2b_tready", 32'(inp_tready), 32'h1);
    send(3'b010, 8'h03); tick();
    chk("b2b_clr", 32'(gpo), 32'h0C);
    send(3'b011, 8'hFF); tick();
    chk("b2b_tgl", 32'(gpo), 32'hF3);

    // 3. pulse 0x81 on 0x01, write held valid through it
    send(3'b000, 8'h01); tick();
    chk("pl_pre", 32'(gpo), 32'h01);
    send(3'b100, 8'h81); tick();
    send(3'b000, 8'h55);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pl_gpo%0d", i), 32'(gpo), 32'h80);
      chk($sformatf("pl_tready%0d", i), 32'(inp_tready), 32'h0);
      chk($sformatf("pl_busy%0d", i), 32'(busy), 32'h1);
      tick();
    end
    chk("pl_restore", 32'(gpo), 32'h01);
    chk("pl_tready_end", 32'(inp_tready), 32'h1);
    chk("pl_busy_end", 32'(busy), 32'h0);
    tick();
    chk("pl_held_wr", 32'(gpo), 32'h55);

    // zero-mask pulse still occupies 4 cycles
    send(3'b100, 8'h00); tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pz_busy%0d", i), 32'(busy), 32'h1);
      chk($sformatf("pz_gpo%0d", i), 32'(gpo), 32'h55);
      tick();
    end
    chk("pz_done", 32'(busy), 32'h0);

    // 4. read-back with backpressure; a write offered meanwhile is ignored
    send(3'b000, 8'h3C); tick();
    send(3'b101, 8'h00); tick();
    send(3'b000, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rd_otv%0d", i), 32'(out_tvalid), 32'h1);
      chk($sformatf("rd_otd%0d", i), 32'(out_tdata), 32'h3C);
      chk($sformatf("rd_tready%0d", i), 32'(inp_tready), 32'h0);
      if (i < 4) tick();
    end
    chk("rd_busy", 32'(busy), 32'h1);
    out_tready = 1'b1;
    tick();
    idle_in();
    chk("rd_otv_done", 32'(out_tvalid), 32'h0);
    chk("rd_tready_done", 32'(inp_tready), 32'h1);
    chk("rd_gpo", 32'(gpo), 32'h3C);
    // ready already high: one-cycle completion
    send(3'b101, 8'h00); tick();
    idle_in();
    chk("rd1_otv", 32'(out_tvalid), 32'h1);
    tick();
    chk("rd1_otv_done", 32'(out_tvalid), 32'h0);
    chk("rd1_tready", 32'(inp_tready), 32'h1);
    out_tready = 1'b0;

    // 5. reserved op
    send(3'b110, 8'hFF); tick();
    idle_in();
    chk("rsv_gpo", 32'(gpo), 32'h3C);
    chk("rsv_otv", 32'(out_tvalid), 32'h0);
    chk("rsv_busy", 32'(busy), 32'h0);

    // 6. reset mid-pulse (counter at 2) and mid-response
    send(3'b100, 8'h0F); tick();
    idle_in();
    chk("mr_pulse", 32'(gpo), 32'h33);
    tick();
    aresetn = 1'b0; #1;
    chk("mr_p_gpo", 32'(gpo), 32'h00);
    chk("mr_p_busy", 32'(busy), 32'h0);
    chk("mr_p_otv", 32'(out_tvalid), 32'h0);
    tick();
    aresetn = 1'b1;
    send(3'b101, 8'h00); tick();
    idle_in();
    chk("mr_r_otv_pre", 32'(out_tvalid), 32'h1);
    aresetn = 1'b0; #1;
    chk("mr_r_otv", 32'(out_tvalid), 32'h0);
    chk("mr_r_busy", 32'(busy), 32'h0);
    chk("mr_r_gpo", 32'(gpo), 32'h00);
    tick();
    aresetn = 1'b1;
    send(3'b000, 8'h11);
    chk("mr_tready", 32'(inp_tready), 32'h1);
    tick();
    idle_in();
    chk("mr_wr", 32'(gpo), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gpo_ctrl.md
Name: gpo_ctrl

Overview:
- Parametrised general-purpose output controller; successor to the plain streaming GPO register.
- Accepts command words on a ready/valid input stream and applies one of several ops to a DW-bit output register driving pins/LEDs: write, set, clear, toggle, timed pulse, read-back.
- Read-back returns the current pin state on a ready/valid output stream with backpressure.
- Sits between a processor-side stream interconnect and board-level outputs.

Parameters:
DW, 8, number of GPO bits (1..32)
INIT_STATE, {DW{1'b0}}, gpo value after reset
PULSE_CYCLES, 16, cycles a PULSE op holds its toggled bits (>=1)

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
inp_tdata  input  DW+3  command: [DW+2:DW] = op, [DW-1:0] = data/mask
inp_tvalid  input  1  command valid
inp_tready  output  1  command accepted when inp_tvalid & inp_tready at a rising edge
out_tdata  output  DW  read-back data
out_tvalid  output  1  read-back valid
out_tready  input  1  read-back consumer ready
gpo  output  DW  registered output pins
busy  output  1  high while a PULSE is running or a read-back is pending

Behaviour:
- Reset (aresetn low, asynchronous, any state): gpo=INIT_STATE, state=IDLE, pulse counter=0, saved mask=0, out_tvalid=0, out_tdata=0. Outputs resume from these values on the first edge after release; any in-flight pulse or response is discarded.
- States: IDLE, PULSE, RESP. inp_tready = (state==IDLE), combinational from the state register only. busy = (state!=IDLE).
- Ops, applied at the accepting edge, gpo visible the next cycle (1-cycle latency):
  - 000 WRITE: gpo <= data.
  - 001 SET: gpo <= gpo | data.
  - 010 CLEAR: gpo <= gpo & ~data.
  - 011 TOGGLE: gpo <= gpo ^ data.
  - 100 PULSE: gpo <= gpo ^ data; save mask=data; counter <= PULSE_CYCLES-1; go to PULSE.
  - 101 READ: out_tdata <= gpo (pre-edge value); out_tvalid <= 1; go to RESP.
  - 110, 111: reserved; consumed, no effect, stay IDLE.
  - WRITE/SET/CLEAR/TOGGLE stay IDLE; back-to-back accepts every cycle allowed.
- PULSE: counter decrements each cycle. When counter==0: gpo <= gpo ^ mask (restore), go to IDLE. Toggled bits are held exactly PULSE_CYCLES cycles. inp_tready=0 throughout; restore and inp_tready=1 appear in the same cycle. A mask of 0 still occupies PULSE_CYCLES cycles with no pin change.
- RESP: out_tvalid and out_tdata hold stable until out_tready=1 at an edge; then out_tvalid <= 0 and go to IDLE. out_tready high in the cycle out_tvalid rises completes in one cycle. gpo is unchanged during RESP.
- out_tvalid never depends combinationally on out_tready. inp_tvalid is ignored outside IDLE.
- Counter width = $clog2(PULSE_CYCLES+1). All arithmetic is unsigned and has no wrap paths.

Test Plan (DW=8, INIT_STATE=8'h00, PULSE_CYCLES=4):
1. Reset, then WRITE 8'hA5 -> gpo=8'h00 during reset; gpo=8'hA5 one cycle after the handshake; inp_tready=1 throughout.
2. Back-to-back SET 8'h0F, CLEAR 8'h03, TOGGLE 8'hFF on consecutive cycles from 8'h00 -> gpo sequence 8'h0F, 8'h0C, 8'hF3 on successive cycles.
3. gpo=8'h01, PULSE 8'h81 -> gpo=8'h80 for exactly 4 cycles with inp_tready=0 and busy=1; then gpo=8'h01, inp_tready=1. A WRITE held valid during the pulse is accepted only after the restore.
4. gpo=8'h3C, READ with out_tready=0 for 5 cycles -> out_tvalid=1 and out_tdata=8'h3C stable; inp_tready=0. On out_tready=1 the transfer completes and inp_tready=1 next cycle.
5. Op 110 with data 8'hFF -> accepted, gpo unchanged, no out_tvalid.
6. Assert aresetn low mid-PULSE (counter=2) and mid-RESP -> immediately gpo=8'h00, out_tvalid=0, busy=0. After release, a WRITE 8'h11 is accepted on the first valid cycle.
